// File: rtl/bounce_updater.sv
// bounce_updater: per-tick physics and scoring engine for the colour-bounce game.
// Each update request evaluates one key/platform hit over NUM_PLATS lanes and
// then moves the ball, counts the score and reshuffles colours on a hit.
//
// Ports:
//   clk_i          clock, everything is posedge
//   reset_i        synchronous active-high reset, overrides all other inputs
//   start_i        update request, sampled only in IDLE
//   keys_i         active-low key per lane
//   plat_pos_i     packed platform positions, lane i at [i*POS_W +: POS_W]
//   ball_pos_o     current ball position
//   prev_ball_o    ball position before the last update
//   ball_color_o   current ball colour
//   plat_colors_o  packed per-lane platform colours
//   score_o        saturating hit count
//   hit_o          one-cycle pulse with done_o on a scoring tick
//   done_o         one-cycle pulse when updated values are valid
//   gameover_o     sticky until reset
//
// state | meaning
// ------+---------------------------------------------------------
// IDLE  | wait for start_i
// EVAL  | decode keys/platforms, register the hit decision
// MOVE  | apply ball/score/colour update, pulse done
// OVER  | ball reached the floor; frozen until reset

module bounce_updater #(
  parameter int                           NUM_PLATS        = 4,
  parameter int                           POS_W            = 7,
  parameter int                           COLOR_W          = 3,
  parameter int                           HIT_WINDOW       = 4,
  parameter int                           BOUNCE_LEN       = 50,
  parameter int                           FLOOR            = 116,
  parameter int                           BALL_START       = 10,
  parameter int                           SCORE_W          = 32,
  parameter logic [COLOR_W-1:0]           INIT_BALL_COLOR  = 3'd1,
  parameter logic [NUM_PLATS*COLOR_W-1:0] INIT_PLAT_COLORS = {3'd4, 3'd3, 3'd2, 3'd1},
  parameter logic [15:0]                  LFSR_SEED        = 16'hACE1
) (
  input  logic                           clk_i,
  input  logic                           reset_i,
  input  logic                           start_i,
  input  logic [NUM_PLATS-1:0]           keys_i,
  input  logic [NUM_PLATS*POS_W-1:0]     plat_pos_i,
  output logic [POS_W-1:0]               ball_pos_o,
  output logic [POS_W-1:0]               prev_ball_o,
  output logic [COLOR_W-1:0]             ball_color_o,
  output logic [NUM_PLATS*COLOR_W-1:0]   plat_colors_o,
  output logic [SCORE_W-1:0]             score_o,
  output logic                           hit_o,
  output logic                           done_o,
  output logic                           gameover_o
);

  localparam int IDX_W = (NUM_PLATS > 1) ? $clog2(NUM_PLATS) : 1;
  localparam int CNT_W = $clog2(BOUNCE_LEN + 1);
  localparam int PW1   = POS_W + 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_EVAL,
    S_MOVE,
    S_OVER
  } state_e;

  state_e                         state_q, state_d;
  logic [POS_W-1:0]               ball_q, ball_d;
  logic [POS_W-1:0]               prev_q, prev_d;
  logic [CNT_W-1:0]               up_q, up_d;
  logic [COLOR_W-1:0]             bc_q, bc_d;
  logic [NUM_PLATS*COLOR_W-1:0]   pc_q, pc_d;
  logic [SCORE_W-1:0]             score_q, score_d;
  logic                           hit_q, hit_d;
  logic                           hit_pulse_q, hit_pulse_d;
  logic                           done_q, done_d;
  logic                           go_q, go_d;
  logic [15:0]                    lfsr_q, lfsr_d;

  logic [3:0]                     low_cnt;
  logic [IDX_W-1:0]               sel_idx;
  logic [POS_W-1:0]               sel_pos;
  logic [COLOR_W-1:0]             sel_col;
  logic                           in_window;
  logic                           hit_now;
  logic [IDX_W-1:0]               pick_raw;
  logic [IDX_W-1:0]               pick;
  logic [NUM_PLATS*COLOR_W-1:0]   pc_rot;

  // Galois LFSR, x^16+x^14+x^13+x^11+1, right-shifting form.
  assign lfsr_d = {1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? 16'hB400 : 16'h0000);

  // Key decode: exactly one low key selects a lane.
  always_comb begin
    low_cnt = 4'd0;
    sel_idx = '0;
    for (int i = 0; i < NUM_PLATS; i++) begin
      if (!keys_i[i]) begin
        low_cnt = low_cnt + 4'd1;
        sel_idx = IDX_W'(i);
      end
    end
  end

  assign sel_pos = plat_pos_i[sel_idx*POS_W +: POS_W];
  assign sel_col = pc_q[sel_idx*COLOR_W +: COLOR_W];

  // Upper bound compared one bit wider so ball_pos + HIT_WINDOW never wraps.
  assign in_window = (sel_pos >= ball_q) &&
                     ({1'b0, sel_pos} <= ({1'b0, ball_q} + PW1'(HIT_WINDOW)));

  assign hit_now = (low_cnt == 4'd1) && (up_q == '0) && (bc_q == sel_col) && in_window;

  // Lane pick for the new ball colour; one conditional subtract is enough
  // because the raw index is below 2*NUM_PLATS.
  assign pick_raw = lfsr_q[IDX_W-1:0];
  always_comb begin
    pick = pick_raw;
    if ({1'b0, pick_raw} >= (IDX_W+1)'(NUM_PLATS)) begin
      pick = pick_raw - IDX_W'(NUM_PLATS);
    end
  end

  always_comb begin
    pc_rot = '0;
    for (int i = 0; i < NUM_PLATS; i++) begin
      pc_rot[i*COLOR_W +: COLOR_W] = pc_q[((i + 1) % NUM_PLATS)*COLOR_W +: COLOR_W];
    end
  end

  always_comb begin
    state_d     = state_q;
    ball_d      = ball_q;
    prev_d      = prev_q;
    up_d        = up_q;
    bc_d        = bc_q;
    pc_d        = pc_q;
    score_d     = score_q;
    hit_d       = hit_q;
    hit_pulse_d = 1'b0;
    done_d      = 1'b0;
    go_d        = go_q;

    case (state_q)
      S_IDLE: begin
        if (start_i) begin
          state_d = S_EVAL;
        end
      end
      S_EVAL: begin
        hit_d   = hit_now;
        state_d = S_MOVE;
      end
      S_MOVE: begin
        prev_d = ball_q;
        if (hit_q || (up_q != '0)) begin
          // A ball pinned at the top ends its ascent immediately.
          if (ball_q == '0) begin
            up_d = '0;
          end else begin
            ball_d = ball_q - POS_W'(1);
            up_d   = hit_q ? CNT_W'(BOUNCE_LEN - 1) : (up_q - CNT_W'(1));
          end
        end else if (ball_q != '1) begin
          ball_d = ball_q + POS_W'(1);
        end

        if (hit_q) begin
          if (score_q != '1) begin
            score_d = score_q + SCORE_W'(1);
          end
          bc_d = pc_q[pick*COLOR_W +: COLOR_W];
          pc_d = pc_rot;
        end

        hit_pulse_d = hit_q;
        done_d      = 1'b1;
        if ({1'b0, ball_d} >= PW1'(FLOOR)) begin
          go_d    = 1'b1;
          state_d = S_OVER;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_OVER: begin
        state_d = S_OVER;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q     <= S_IDLE;
      ball_q      <= POS_W'(BALL_START);
      prev_q      <= POS_W'(BALL_START);
      up_q        <= '0;
      bc_q        <= INIT_BALL_COLOR;
      pc_q        <= INIT_PLAT_COLORS;
      score_q     <= '0;
      hit_q       <= 1'b0;
      hit_pulse_q <= 1'b0;
      done_q      <= 1'b0;
      go_q        <= 1'b0;
      lfsr_q      <= LFSR_SEED;
    end else begin
      state_q     <= state_d;
      ball_q      <= ball_d;
      prev_q      <= prev_d;
      up_q        <= up_d;
      bc_q        <= bc_d;
      pc_q        <= pc_d;
      score_q     <= score_d;
      hit_q       <= hit_d;
      hit_pulse_q <= hit_pulse_d;
      done_q      <= done_d;
      go_q        <= go_d;
      lfsr_q      <= lfsr_d;
    end
  end

  assign ball_pos_o    = ball_q;
  assign prev_ball_o   = prev_q;
  assign ball_color_o  = bc_q;
  assign plat_colors_o = pc_q;
  assign score_o       = score_q;
  assign hit_o         = hit_pulse_q;
  assign done_o        = done_q;
  assign gameover_o    = go_q;

endmodule

// File: tb/tb_bounce_updater.sv
module tb_bounce_updater;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [3:0]  keys = 4'hF;
  logic [27:0] plat = '0;

  logic [6:0]  ball_pos, prev_ball;
  logic [2:0]  ball_color;
  logic [11:0] plat_colors;
  logic [31:0] score;
  logic        hit, done, gameover;

  always #5 clk = ~clk;

  bounce_updater dut (
    .clk_i        (clk),
    .reset_i      (reset),
    .start_i      (start),
    .keys_i       (keys),
    .plat_pos_i   (plat),
    .ball_pos_o   (ball_pos),
    .prev_ball_o  (prev_ball),
    .ball_color_o (ball_color),
    .plat_colors_o(plat_colors),
    .score_o      (score),
    .hit_o        (hit),
    .done_o       (done),
    .gameover_o   (gameover)
  );

  int n_vec = 0;
  int n_err = 0;

  // Reference model state
  int m_ball, m_prev, m_up, m_score, m_bc;
  int m_pc[4];
  bit m_go, m_hit;
  logic [15:0] m_lfsr;

  // Free-running reference LFSR: polynomial x^16+x^14+x^13+x^11+1.
  always @(posedge clk) begin
    if (reset) m_lfsr <= 16'hACE1;
    else       m_lfsr <= {1'b0, m_lfsr[15:1]} ^ (m_lfsr[0] ? 16'hB400 : 16'h0000);
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_ball = 10; m_prev = 10; m_up = 0; m_score = 0; m_bc = 1;
    m_pc[0] = 1; m_pc[1] = 2; m_pc[2] = 3; m_pc[3] = 4;
    m_go = 0; m_hit = 0;
  endtask

  task automatic check_state(input string tag, input bit exp_done, input bit exp_hit);
    logic [11:0] epc;
    for (int i = 0; i < 4; i++) epc[i*3 +: 3] = 3'(m_pc[i]);
    chk({tag, "/ball"},  64'(ball_pos),   64'(m_ball));
    chk({tag, "/prev"},  64'(prev_ball),  64'(m_prev));
    chk({tag, "/bcol"},  64'(ball_color), 64'(m_bc));
    chk({tag, "/pcol"},  64'(plat_colors), 64'(epc));
    chk({tag, "/score"}, 64'(score),      64'(m_score));
    chk({tag, "/hit"},   64'(hit),        64'(exp_hit));
    chk({tag, "/done"},  64'(done),       64'(exp_done));
    chk({tag, "/gover"}, 64'(gameover),   64'(m_go));
  endtask

  task automatic model_step(input logic [3:0] k, input logic [27:0] pp, input logic [15:0] lf);
    int nlow, sel, p, idx;
    int old_pc[4];
    bit h;
    nlow = 0; sel = 0;
    for (int i = 0; i < 4; i++) if (k[i] == 1'b0) begin nlow++; sel = i; end
    p = int'(pp[sel*7 +: 7]);
    h = (nlow == 1) && (m_up == 0) && (m_bc == m_pc[sel]) && (p >= m_ball) && (p <= m_ball + 4);
    m_prev = m_ball;
    if (h || m_up != 0) begin
      if (m_ball == 0) m_up = 0;
      else begin
        m_ball = m_ball - 1;
        m_up = h ? 49 : m_up - 1;
      end
    end else if (m_ball < 127) begin
      m_ball = m_ball + 1;
    end
    if (h) begin
      m_score = m_score + 1;
      idx = int'(lf % 16'd4);
      old_pc = m_pc;
      m_bc = old_pc[idx];
      for (int i = 0; i < 4; i++) m_pc[i] = old_pc[(i + 1) % 4];
    end
    m_hit = h;
    if (m_ball >= 116) m_go = 1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1; start = 1'b0; keys = 4'hF;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    model_reset();
  endtask

  // One update request: start sampled at E0, keys/plat at E1, results after E2.
  task automatic tick(input logic [3:0] k, input logic [27:0] pp, input string tag);
    logic [15:0] lf;
    @(negedge clk);
    start = 1'b1; keys = k; plat = pp;
    @(posedge clk); #1;
    start = 1'b0;
    chk({tag, "/done_e0"}, 64'(done), 64'(0));
    @(posedge clk); #1;
    lf = m_lfsr;
    chk({tag, "/done_e1"}, 64'(done), 64'(0));
    @(posedge clk); #1;
    if (!m_go) begin
      model_step(k, pp, lf);
      check_state(tag, 1'b1, m_hit);
    end else begin
      check_state(tag, 1'b0, 1'b0);
    end
  endtask

  function automatic logic [27:0] plat_at(input int lane, input int pos);
    logic [27:0] v;
    v = '0;
    v[lane*7 +: 7] = 7'(pos);
    return v;
  endfunction

  function automatic int match_lane();
    for (int j = 0; j < 4; j++) if (m_pc[j] == m_bc) return j;
    return 0;
  endfunction

  function automatic logic [3:0] key_for(input int lane);
    logic [3:0] v;
    v = 4'hF;
    v[lane] = 1'b0;
    return v;
  endfunction

  task automatic climb(input int target);
    for (int g = 0; g < 300 && m_ball != target; g++) tick(4'hF, '0, "climb");
  endtask

  initial begin
    int j, m, pos, r;
    logic [27:0] pp;
    logic [3:0] kk;

    do_reset();
    #1;
    check_state("reset", 1'b0, 1'b0);

    // First tick, no keys
    tick(4'hF, '0, "first");
    chk("first/ball_const", 64'(ball_pos), 64'(11));
    chk("first/prev_const", 64'(prev_ball), 64'(10));

    // Hit at 60 with platform 2 below, then full ascent
    do_reset();
    climb(60);
    j = match_lane();
    tick(key_for(j), plat_at(j, 62), "hit60");
    chk("hit60/ball_const", 64'(ball_pos), 64'(59));
    chk("hit60/hit_const", 64'(hit), 64'(1));
    chk("hit60/score_const", 64'(score), 64'(1));
    for (int i = 0; i < 49; i++) begin
      if (i == 10) begin
        j = match_lane();
        tick(key_for(j), plat_at(j, m_ball), "key_ascending");
      end else begin
        tick(4'hF, '0, "ascent");
      end
    end
    chk("ascent_end/ball_const", 64'(ball_pos), 64'(10));
    tick(4'hF, '0, "after_ascent");
    chk("after_ascent/ball_const", 64'(ball_pos), 64'(11));

    // No-hit cases with the ball descending
    j = match_lane();
    tick(key_for(j), plat_at(j, m_ball + 5), "out_of_window");
    m = (j + 1) % 4;
    for (int q = 0; q < 4; q++) if (m_pc[q] != m_bc) m = q;
    tick(key_for(m), plat_at(m, m_ball + 1), "colour_mismatch");
    j = match_lane();
    kk = key_for(j);
    kk[(j + 1) % 4] = 1'b0;
    tick(kk, plat_at(j, m_ball) | plat_at((j + 1) % 4, m_ball), "two_keys");
    chk("nohit/score_const", 64'(score), 64'(1));
    chk("nohit/ball_const", 64'(ball_pos), 64'(14));

    // Ball pinned at the top of the screen
    do_reset();
    climb(31);
    j = match_lane();
    tick(key_for(j), plat_at(j, 31), "hit31");
    for (int i = 0; i < 29; i++) tick(4'hF, '0, "ascent2");
    chk("top/ball1_const", 64'(ball_pos), 64'(1));
    tick(4'hF, '0, "top_a");
    chk("top/ball0_const", 64'(ball_pos), 64'(0));
    tick(4'hF, '0, "top_b");
    chk("top/ball0_stay_const", 64'(ball_pos), 64'(0));
    tick(4'hF, '0, "top_c");
    chk("top/ball1_again_const", 64'(ball_pos), 64'(1));

    // Floor and game over
    do_reset();
    climb(115);
    tick(4'hF, '0, "floor");
    chk("floor/ball_const", 64'(ball_pos), 64'(116));
    chk("floor/gover_const", 64'(gameover), 64'(1));
    for (int i = 0; i < 3; i++) tick(key_for(0), plat_at(0, m_ball), "over_ignored");

    // Reset the cycle after a start sample aborts the tick
    @(negedge clk);
    start = 1'b1; keys = key_for(0); plat = plat_at(0, 116);
    @(posedge clk); #1;
    start = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk); #1;
    model_reset();
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      chk("abort/no_done", 64'(done), 64'(0));
    end
    check_state("abort", 1'b0, 1'b0);
    tick(key_for(0), plat_at(0, 10), "post_abort_hit");

    // Randomised play against the model
    do_reset();
    for (int t = 0; t < 150; t++) begin
      r = $urandom_range(0, 3);
      pp = '0;
      for (int q = 0; q < 4; q++) begin
        pos = m_ball + $urandom_range(0, 7) - 1;
        if (pos < 0) pos = 0;
        if (pos > 127) pos = 127;
        pp[q*7 +: 7] = 7'(pos);
      end
      case (r)
        0: kk = 4'hF;
        1: kk = key_for(match_lane());
        2: kk = key_for($urandom_range(0, 3));
        default: kk = 4'($urandom);
      endcase
      tick(kk, pp, "random");
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
